// File: rtl/deferred_report_pkg.sv
// Shared types and defaults for the deferred report scheduler and its arbiter.
package deferred_report_pkg;

  typedef enum logic {IDLE, DRAIN} drs_state_e;

  typedef struct packed {
    logic vld;
    logic fail;
  } slot_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/deferred_report_scheduler_if.sv
// Checker-side inputs and the shared report channel of the deferred report scheduler.
interface deferred_report_scheduler_if #(
  parameter int N_REQ = 4
) ();
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] chk_valid;
  logic [N_REQ-1:0] chk_fail;
  logic [N_REQ-1:0] flush;
  logic             commit;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [IW-1:0]    rpt_idx;
  logic             rpt_fail;

  modport master (
    output chk_valid, chk_fail, flush, commit, rpt_ready,
    input  rpt_valid, rpt_idx, rpt_fail
  );

  modport slave (
    input  chk_valid, chk_fail, flush, commit, rpt_ready,
    output rpt_valid, rpt_idx, rpt_fail
  );
endinterface

// File: rtl/deferred_report_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (cyclically) wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] cand_idx [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      assign cand_idx[gi] = IW'((int'(ptr) + gi) % N);
    end
  endgenerate

  // Scan from the farthest offset down so the closest requester overwrites last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        gnt              = '0;
        gnt[cand_idx[k]] = 1'b1;
        gnt_idx          = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/deferred_report_scheduler.sv
// Holds pending/mature checker results, drains matured ones round-robin to one reporter,
// and keeps saturating pass/fail statistics.
module deferred_report_scheduler
  import deferred_report_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  deferred_report_scheduler_if.slave   bus,
  output logic                         busy,
  output logic [CNT_W-1:0]             pass_cnt,
  output logic [CNT_W-1:0]             fail_cnt,
  output logic                         overwrite
);

  slot_t [N_REQ-1:0] pend_q, pend_d, pend_fl, mature_q, mature_d, arb_src;
  drs_state_e        state_q, state_d;
  logic              commit_q, commit_d;
  logic              rpt_valid_q, rpt_valid_d, rpt_fail_q, rpt_fail_d;
  logic [IW-1:0]     rpt_idx_q, rpt_idx_d, ptr_q, ptr_d, next_ptr, arb_ptr, arb_idx;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic              overwrite_q, overwrite_d;
  logic [N_REQ-1:0]  arb_req, arb_gnt;
  logic              accept, eff_commit, any_pend, take;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (arb_req),
    .ptr     (arb_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    accept     = rpt_valid_q & bus.rpt_ready;
    eff_commit = bus.commit | commit_q;
    any_pend   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      pend_fl[i] = bus.flush[i] ? '0 : pend_q[i];
      any_pend   = any_pend | pend_fl[i].vld;
    end
    take     = (state_q == IDLE) && eff_commit && any_pend;
    next_ptr = (rpt_idx_q == IW'(N_REQ - 1)) ? '0 : rpt_idx_q + IW'(1);

    mature_d = mature_q;
    if (take) begin
      mature_d = pend_fl;
    end else if (accept) begin
      mature_d[rpt_idx_q].vld = 1'b0;
    end

    // Loads landing in the cycle a slot matures are fresh results, not overwrites.
    overwrite_d = overwrite_q;
    for (int i = 0; i < N_REQ; i++) begin
      pend_d[i] = take ? '0 : pend_fl[i];
      if (bus.chk_valid[i]) begin
        if (pend_d[i].vld) overwrite_d = 1'b1;
        pend_d[i].vld  = 1'b1;
        pend_d[i].fail = bus.chk_fail[i];
      end
    end

    arb_src = take ? pend_fl : mature_d;
    arb_ptr = accept ? next_ptr : ptr_q;
    for (int i = 0; i < N_REQ; i++) arb_req[i] = arb_src[i].vld;

    state_d     = state_q;
    commit_d    = commit_q;
    rpt_valid_d = rpt_valid_q;
    rpt_idx_d   = rpt_idx_q;
    rpt_fail_d  = rpt_fail_q;
    ptr_d       = ptr_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;

    case (state_q)
      IDLE: begin
        if (eff_commit) commit_d = 1'b0;
        if (take) begin
          state_d     = DRAIN;
          rpt_valid_d = 1'b1;
          rpt_idx_d   = arb_idx;
          rpt_fail_d  = arb_src[arb_idx].fail;
        end
      end
      DRAIN: begin
        if (bus.commit) commit_d = 1'b1;
        if (accept) begin
          ptr_d = next_ptr;
          if (rpt_fail_q) begin
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
          end else begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
          end
          if (|arb_gnt) begin
            rpt_idx_d  = arb_idx;
            rpt_fail_d = arb_src[arb_idx].fail;
          end else begin
            rpt_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      mature_q    <= '0;
      commit_q    <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_idx_q   <= '0;
      rpt_fail_q  <= 1'b0;
      ptr_q       <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      overwrite_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mature_q    <= mature_d;
      commit_q    <= commit_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_idx_q   <= rpt_idx_d;
      rpt_fail_q  <= rpt_fail_d;
      ptr_q       <= ptr_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      overwrite_q <= overwrite_d;
    end
  end

  assign bus.rpt_valid = rpt_valid_q;
  assign bus.rpt_idx   = rpt_idx_q;
  assign bus.rpt_fail  = rpt_fail_q;
  assign busy          = (state_q == DRAIN);
  assign pass_cnt      = pass_cnt_q;
  assign fail_cnt      = fail_cnt_q;
  assign overwrite     = overwrite_q;

endmodule

// File: tb/tb_deferred_report_scheduler.sv
// Scoreboard bench: a queue-level model predicts each drained report; a negedge monitor compares.
module tb_deferred_report_scheduler;

  localparam int N = 4;

  typedef struct {
    int idx;
    bit fail;
  } rep_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deferred_report_scheduler_if #(.N_REQ(N)) bus ();
  deferred_report_scheduler_if #(.N_REQ(N)) bus2 ();

  logic        busy, overwrite, busy2, overwrite2;
  logic [15:0] pass_cnt, fail_cnt;
  logic [1:0]  pass_cnt2, fail_cnt2;

  deferred_report_scheduler #(.N_REQ(N), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .overwrite(overwrite)
  );

  // Narrow-counter copy fed the same stimulus to exercise saturation.
  deferred_report_scheduler #(.N_REQ(N), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .busy(busy2),
    .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .overwrite(overwrite2)
  );

  assign bus2.chk_valid = bus.chk_valid;
  assign bus2.chk_fail  = bus.chk_fail;
  assign bus2.flush     = bus.flush;
  assign bus2.commit    = bus.commit;
  assign bus2.rpt_ready = bus.rpt_ready;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit   mpv [N];
  bit   mpf [N];
  bit   mcq, mover;
  int   mptr, mpass, mfail, mpass2, mfail2;
  rep_t mbatch[$];
  rep_t exp_q[$];
  bit   m_idle, m_any;
  rep_t m_e;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin mpv[i] = 0; mpf[i] = 0; end
      mcq = 0; mover = 0; mptr = 0;
      mpass = 0; mfail = 0; mpass2 = 0; mfail2 = 0;
      mbatch.delete();
      exp_q.delete();
    end else begin
      m_idle = (mbatch.size() == 0);
      for (int i = 0; i < N; i++) if (bus.flush[i]) mpv[i] = 0;
      if (m_idle) begin
        if (bus.commit || mcq) begin
          mcq   = 0;
          m_any = 0;
          for (int i = 0; i < N; i++) m_any |= mpv[i];
          if (m_any) begin
            for (int k = 0; k < N; k++) begin
              int j;
              j = (mptr + k) % N;
              if (mpv[j]) begin
                m_e.idx  = j;
                m_e.fail = mpf[j];
                mbatch.push_back(m_e);
                exp_q.push_back(m_e);
                mpv[j] = 0;
              end
            end
          end
        end
      end else begin
        if (bus.commit) mcq = 1;
        if (bus.rpt_ready) begin
          m_e = mbatch.pop_front();
          if (m_e.fail) begin
            if (mfail < 65535) mfail++;
            if (mfail2 < 3) mfail2++;
          end else begin
            if (mpass < 65535) mpass++;
            if (mpass2 < 3) mpass2++;
          end
          mptr = (m_e.idx + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.chk_valid[i]) begin
          if (mpv[i]) mover = 1;
          mpv[i] = 1;
          mpf[i] = bus.chk_fail[i];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("rpt_valid", bus.rpt_valid, mbatch.size() != 0);
      check("busy", busy, mbatch.size() != 0);
      check("pass_cnt", pass_cnt, mpass);
      check("fail_cnt", fail_cnt, mfail);
      check("overwrite", overwrite, mover);
      check("pass_cnt_w2", pass_cnt2, mpass2);
      check("fail_cnt_w2", fail_cnt2, mfail2);
      if (bus.rpt_valid) begin
        if (exp_q.size() == 0) begin
          check("report_unexpected", 1, 0);
        end else begin
          check("rpt_idx", bus.rpt_idx, exp_q[0].idx);
          check("rpt_fail", bus.rpt_fail, exp_q[0].fail);
          if (bus.rpt_ready) begin
            $display("report idx=%0d fail=%0d pass_cnt=%0d fail_cnt=%0d",
                     bus.rpt_idx, bus.rpt_fail, pass_cnt, fail_cnt);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [N-1:0] cv, input logic [N-1:0] cf,
                      input logic [N-1:0] fl, input logic cm, input logic rdy);
    bus.chk_valid = cv;
    bus.chk_fail  = cf;
    bus.flush     = fl;
    bus.commit    = cm;
    bus.rpt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, '0, '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (mbatch.size() == 0 && !mcq) break;
      step('0, '0, '0, 1'b0, 1'b1);
    end
    check("drain_timeout_busy", busy, 0);
  endtask

  initial begin
    bus.chk_valid = '0; bus.chk_fail = '0; bus.flush = '0;
    bus.commit = 1'b0; bus.rpt_ready = 1'b0;
    do_reset();
    mon_en = 1;
    check("reset_rpt_valid", bus.rpt_valid, 0);
    check("reset_pass", pass_cnt, 0);

    // Two results, commit next cycle: idx0 pass then idx2 fail
    step(4'b0101, 4'b0100, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    check("t1_latency_valid", bus.rpt_valid, 1);
    drain();
    check("t1_pass", pass_cnt, 1);
    check("t1_fail", fail_cnt, 1);

    // Flushed result never reported
    do_reset();
    step(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    repeat (3) step('0, '0, '0, 1'b0, 1'b1);
    check("t2_no_report", bus.rpt_valid, 0);
    check("t2_fail", fail_cnt, 0);

    // Same-cycle flush and load keeps the new result
    do_reset();
    step(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    drain();
    check("t3_pass", pass_cnt, 1);

    // Stalled drain, plus commit during DRAIN
    do_reset();
    step(4'b1111, 4'b0110, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    repeat (4) step('0, '0, '0, 1'b0, 1'b0);
    step(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0);
    drain();
    check("t4_pass", pass_cnt, 3);
    check("t4_fail", fail_cnt, 2);

    // Overwrite before commit
    do_reset();
    step(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1);
    step(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check("t5_overwrite", overwrite, 1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    drain();
    check("t5_pass", pass_cnt, 1);
    check("t5_fail", fail_cnt, 0);

    // Narrow counter saturation, then reset mid-drain
    do_reset();
    for (int r = 0; r < 5; r++) begin
      step(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1);
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
      drain();
    end
    check("t6_pass_w2_sat", pass_cnt2, 3);
    check("t6_pass_w16", pass_cnt, 5);
    step(4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    rst = 1'b1;
    step('0, '0, '0, 1'b0, 1'b0);
    check("t6_rst_valid", bus.rpt_valid, 0);
    check("t6_rst_pass", pass_cnt, 0);
    rst = 1'b0;
    step('0, '0, '0, 1'b1, 1'b1);
    check("t6_rst_dropped", bus.rpt_valid, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] cv, cf, fl;
      cv = N'($urandom) & N'($urandom);
      cf = N'($urandom);
      fl = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      step(cv, cf, fl, $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
